// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared state encoding, op codes and default width for the mul/div sequencer
package mcycle_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/mcycle_ctrl_if.sv
// mcycle_ctrl_if: decoder/datapath bundle (master drives M_Start/MCycleOp/CondEx/Flush/Early, slave drives Load/Step/Fix/Done/Busy/Stall/OpQ/Count)
interface mcycle_ctrl_if #(parameter int WIDTH = mcycle_pkg::DEF_WIDTH);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  logic M_Start, MCycleOp, CondEx, Flush, Early;
  logic Load, Step, Fix, Done, Busy, Stall, OpQ;
  logic [CNT_W-1:0] Count;
  modport master(output M_Start, MCycleOp, CondEx, Flush, Early,
                 input Load, Step, Fix, Done, Busy, Stall, OpQ, Count);
  modport slave(input M_Start, MCycleOp, CondEx, Flush, Early,
                output Load, Step, Fix, Done, Busy, Stall, OpQ, Count);
endinterface

// File: rtl/mcycle_iter_cnt.sv
// mcycle_iter_cnt: clear/enable iteration counter saturating at WIDTH-1 (clk, rst, clr_i, en_i in; cnt_o, last_o terminal flag out)
module mcycle_iter_cnt
  import mcycle_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign last_o = cnt_q == CNT_W'(WIDTH - 1);
  assign cnt_o  = cnt_q;
  always_comb cnt_d = clr_i ? '0 : (en_i && !last_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: mul/div sequencer (CLK, RESET, bus.slave: M_Start/MCycleOp/CondEx/Flush/Early in, Load/Step/Fix/Done/Busy/Stall/OpQ/Count out); MCYCLE_EARLY_EXIT_EN enables early multiply exit
module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         CLK,
  input  logic         RESET,
  mcycle_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic op_q, go, load, last, fin;
  assign go   = bus.M_Start & bus.CondEx & ~bus.Flush;
  assign load = (state_q == IDLE) & go;
`ifdef MCYCLE_EARLY_EXIT_EN
  assign fin = last | ((op_q == OP_MUL) & bus.Early);
`else
  assign fin = last;
`endif
  always_comb
    state_d = bus.Flush ? IDLE :
              state_q == IDLE ? (go ? RUN : IDLE) :
              state_q == RUN  ? (fin ? (op_q == OP_DIV ? FIX : DONE) : RUN) :
              state_q == FIX  ? DONE : IDLE;
  always_ff @(posedge CLK)
    if (RESET) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
    end else begin
      state_q <= state_d;
      if (load) op_q <= bus.MCycleOp;
    end
  mcycle_iter_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk   (CLK),
    .rst   (RESET),
    .clr_i (load | bus.Flush),
    .en_i  (state_q == RUN),
    .cnt_o (bus.Count),
    .last_o(last)
  );
  assign bus.Load  = load;
  assign bus.Step  = state_q == RUN;
  assign bus.Fix   = state_q == FIX;
  assign bus.Done  = (state_q == DONE) & ~bus.Flush;
  assign bus.Busy  = (state_q == RUN) | (state_q == FIX);
  assign bus.Stall = load | bus.Busy;
  assign bus.OpQ   = op_q;
endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: scoreboard bench for the mul/div sequencer
module tb_mcycle_ctrl;
  import mcycle_pkg::*;
  localparam int W  = 32;
  localparam int CW = $clog2(W) + 1;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  mcycle_ctrl_if #(.WIDTH(W)) bus ();
  mcycle_ctrl #(.WIDTH(W)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct {
    string          tag;
    int             cyc;
    logic [6+CW:0]  v;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [CW-1:0] e_cnt = '0;
  logic e_op = 1'b0;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK)
    if (sb.size() != 0) begin
      exp_t e;
      logic [6+CW:0] a;
      e = sb.pop_front();
      a = {bus.Load, bus.Step, bus.Fix, bus.Done, bus.Busy, bus.Stall, bus.OpQ, bus.Count};
      n_cmp++;
      if (a !== e.v) begin
        n_bad++;
        $display("FAIL %s cyc %0d: {Load,Step,Fix,Done,Busy,Stall,OpQ,Count} got %b exp %b", e.tag, e.cyc, a, e.v);
      end
    end
  task automatic drive(input logic ms, input logic op, input logic ce, input logic fl,
                       input logic ea, input logic [5:0] o, input string tag);
    bus.M_Start  = ms;
    bus.MCycleOp = op;
    bus.CondEx   = ce;
    bus.Flush    = fl;
    bus.Early    = ea;
    sb.push_back('{tag, cyc, {o, e_op, e_cnt}});
    @(posedge CLK);
    #1;
  endtask
  task automatic idle(input int n, input logic ms, input logic ce, input logic fl, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(ms, 1'b0, ce, fl, 1'b0, 6'b000000, tag);
      if (fl) e_cnt = '0;
    end
  endtask
  task automatic op_seq(input logic op, input int tog_at, input int early_at, input int abort_at,
                        input bit abort_rst, input string tag);
    int last_run, done_at;
    bit ex;
    ex = 1'b0;
`ifdef MCYCLE_EARLY_EXIT_EN
    ex = (op == OP_MUL) && (early_at > 0);
`endif
    last_run = ex ? early_at : W;
    done_at  = last_run + 1 + ((op == OP_DIV) ? 1 : 0);
    for (int c = 0; c <= done_at; c++) begin
      logic opi, fl, ea;
      logic [5:0] o;
      bit ab;
      opi = (tog_at >= 0 && c >= tog_at) ? ~op : op;
      ab  = (c == abort_at);
      fl  = ab && !abort_rst;
      ea  = (c == early_at);
      o   = (c == 0) ? 6'b100001 : (c <= last_run) ? 6'b010011 : (c < done_at) ? 6'b001011 : 6'b000100;
      if (ab && c == done_at) o = 6'b000000;
      if (ab && abort_rst) RESET = 1'b1;
      drive(1'b1, opi, 1'b1, fl, ea, o, tag);
      RESET = 1'b0;
      if (ab) begin
        e_cnt = '0;
        if (abort_rst) e_op = 1'b0;
        return;
      end
      if (c == 0) begin
        e_op  = op;
        e_cnt = '0;
      end else if (c <= last_run) e_cnt = (e_cnt == CW'(W - 1)) ? e_cnt : e_cnt + 1'b1;
    end
  endtask
  initial begin
    bus.M_Start  = 1'b0;
    bus.MCycleOp = 1'b0;
    bus.CondEx   = 1'b0;
    bus.Flush    = 1'b0;
    bus.Early    = 1'b0;
    @(posedge CLK);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "reset");
    RESET = 1'b0;
    idle(2, 1'b0, 1'b0, 1'b0, "idle");
    op_seq(OP_MUL, -1, -1, -1, 1'b0, "mul");
    idle(1, 1'b0, 1'b0, 1'b0, "gap");
    op_seq(OP_DIV, -1, -1, -1, 1'b0, "div");
    idle(5, 1'b1, 1'b0, 1'b0, "condex0");
    idle(1, 1'b1, 1'b1, 1'b1, "flush_idle");
    op_seq(OP_MUL, -1, -1, 10, 1'b0, "flush_run");
    idle(1, 1'b0, 1'b0, 1'b0, "after_flush");
    op_seq(OP_MUL, -1, -1, -1, 1'b0, "restart");
    op_seq(OP_MUL, 5, -1, -1, 1'b0, "toggle");
    op_seq(OP_DIV, -1, -1, -1, 1'b0, "b2b_div");
    op_seq(OP_DIV, -1, -1, 34, 1'b0, "flush_done");
    idle(1, 1'b0, 1'b0, 1'b0, "after_fdone");
    op_seq(OP_DIV, -1, -1, 7, 1'b1, "reset_run");
    idle(2, 1'b0, 1'b0, 1'b0, "after_reset");
    op_seq(OP_MUL, -1, 5, -1, 1'b0, "early_mul");
    op_seq(OP_DIV, -1, 5, -1, 1'b0, "early_div");
    idle(2, 1'b0, 1'b0, 1'b0, "tail");
    @(negedge CLK);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending got %0d exp 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
